// File: rtl/uart_tx_arbiter.sv
// Round-robin controller sharing one uart_tx serializer among N_REQ byte producers,
// with a watchdog that recovers when the transmitter never reports completion.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 125_004,
    parameter int unsigned ID_W           = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic [ID_W-1:0]    grant_id,
    output logic               ctrl_busy,
    output logic               err_timeout
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  last_grant_nxt;
    logic [ID_W-1:0]  grant_id_nxt;
    logic [ID_W-1:0]  winner;
    logic [7:0]       tx_data_nxt;
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_cnt_nxt;
    logic             tx_start_nxt;
    logic             err_nxt;
    logic             ctrl_busy_nxt;
    logic             found;
    logic [N_REQ-1:0] rot;

    // First valid requester searching upward from just after the last one served.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        rot    = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            rot = req_valid >> ((32'(last_grant) + i) % N_REQ);
            if (!found && rot[0]) begin
                found  = 1'b1;
                winner = ID_W'((32'(last_grant) + i) % N_REQ);
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant_id_nxt   = grant_id;
        tx_data_nxt    = tx_data;
        wd_cnt_nxt     = wd_cnt;
        tx_start_nxt   = 1'b0;
        err_nxt        = 1'b0;
        req_ready      = '0;

        case (state)
            S_IDLE: begin
                // A busy serializer (e.g. frame still running after reset) blocks grants.
                if (!tx_busy && found) begin
                    req_ready      = N_REQ'(1) << winner;
                    tx_data_nxt    = 8'(req_data >> (32'(winner) * 8));
                    grant_id_nxt   = winner;
                    last_grant_nxt = winner;
                    tx_start_nxt   = 1'b1;
                    state_nxt      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wd_cnt_nxt = '0;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                wd_cnt_nxt = wd_cnt + CNT_W'(1);
                if (tx_done) begin
                    state_nxt = S_IDLE;
                end else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (rst) begin
            req_ready = '0;
        end
        ctrl_busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last_grant  <= ID_W'(N_REQ - 1);
            grant_id    <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            ctrl_busy   <= 1'b0;
            err_timeout <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            grant_id    <= grant_id_nxt;
            tx_data     <= tx_data_nxt;
            tx_start    <= tx_start_nxt;
            ctrl_busy   <= ctrl_busy_nxt;
            err_timeout <= err_nxt;
            wd_cnt      <= wd_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a transaction-level controller model predicts
// grants, starts and timeouts; a separate monitor checks them as the DUT emits them.
module tb_uart_tx_arbiter;
    localparam int N        = 4;
    localparam int TO       = 20;
    localparam int D_NORMAL = 12;
    localparam int D_COINC  = 20;

    localparam int P_NONE    = 0;
    localparam int P_SINGLE  = 1;
    localparam int P_CONTEND = 2;
    localparam int P_RANDOM  = 3;

    localparam int U_NORMAL = 0;
    localparam int U_STUB   = 1;
    localparam int U_COINC  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic          tx_done;
    logic [2:0]    grant_id;
    logic          ctrl_busy;
    logic          err_timeout;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO), .ID_W(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id),
        .ctrl_busy(ctrl_busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int data; int cyc; } start_t;
    start_t sq[$];
    int     eq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stimulus control
    bit   rst_cmd, rand_rst, set_pend;
    logic [N-1:0]   set_v;
    logic [8*N-1:0] set_d;
    int   pmode, u_mode;

    // Transmitter model
    bit u_active;
    int u_k, u_d;

    // Controller reference model (transaction level)
    bit   m_active;
    int   m_last, m_launch, m_gid, m_data;
    bit   rst_prev, s_start;
    logic [N-1:0] acc;

    // Monitor bookkeeping
    int n_start = 0, n_done = 0, n_err = 0;
    bit contend, arm;
    int contend_next, last_done, first_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic load(input logic [N-1:0] v, input logic [8*N-1:0] d);
        set_v = v; set_d = d; set_pend = 1'b1;
    endtask

    task automatic uart_update();
        tx_done = 1'b0;
        if (u_active) begin
            u_k++;
            if (u_k >= u_d) begin
                tx_done = 1'b1; tx_busy = 1'b0; u_active = 1'b0;
            end
        end else if (s_start && u_mode != U_STUB) begin
            u_active = 1'b1; u_k = 1; tx_busy = 1'b1;
            u_d = (u_mode == U_COINC) ? D_COINC : D_NORMAL;
        end
    endtask

    task automatic drive_reqs();
        if (rst_cmd && rand_rst) begin
            req_valid = N'($urandom);
            req_data  = ($urandom);
        end
        for (int k = 0; k < N; k++) begin
            case (pmode)
                P_CONTEND: ;
                P_RANDOM: begin
                    if (acc[k]) begin
                        if ($urandom_range(1) == 1) req_data[8*k +: 8] = 8'($urandom);
                        else req_valid[k] = 1'b0;
                    end else if (req_valid[k]) begin
                        if ($urandom_range(15) == 0) req_valid[k] = 1'b0;
                    end else if ($urandom_range(3) == 0) begin
                        req_valid[k] = 1'b1;
                        req_data[8*k +: 8] = 8'($urandom);
                    end
                end
                default: if (acc[k]) req_valid[k] = 1'b0;
            endcase
        end
        if (set_pend) begin
            req_valid = set_v; req_data = set_d; set_pend = 1'b0;
        end
    endtask

    task automatic model_check();
        logic [N-1:0] exp_rdy;
        int  w;
        bit  found;
        if (rst) begin
            check("ready_in_reset", 32'(req_ready), 32'd0);
            if (rst_prev) begin
                check("rst_tx_start", 32'(tx_start), 32'd0);
                check("rst_tx_data", 32'(tx_data), 32'd0);
                check("rst_grant_id", 32'(grant_id), 32'd0);
                check("rst_ctrl_busy", 32'(ctrl_busy), 32'd0);
                check("rst_err_timeout", 32'(err_timeout), 32'd0);
            end
            m_active = 1'b0;
            m_last   = N - 1;
        end else begin
            exp_rdy = '0; found = 1'b0; w = 0;
            if (!m_active && !tx_busy) begin
                for (int k = 1; k <= N; k++) begin
                    if (!found && req_valid[2'((m_last + k) % N)]) begin
                        found = 1'b1;
                        w = (m_last + k) % N;
                    end
                end
            end
            if (found) exp_rdy[2'(w)] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("ctrl_busy", 32'(ctrl_busy), 32'(m_active));
            if (m_active) begin
                check("grant_id_hold", 32'(grant_id), 32'(m_gid));
                check("tx_data_hold", 32'(tx_data), 32'(m_data));
            end
            if (found) begin
                m_active = 1'b1;
                m_launch = cyc + 1;
                m_last   = w;
                m_gid    = w;
                m_data   = int'(8'(req_data >> (8 * w)));
                sq.push_back('{id: w, data: m_data, cyc: cyc + 1});
            end else if (m_active && cyc > m_launch) begin
                if (tx_done) begin
                    m_active = 1'b0;
                end else if (cyc - m_launch - 1 == TO - 1) begin
                    m_active = 1'b0;
                    eq.push_back(cyc + 1);
                end
            end
        end
        rst_prev = rst;
        s_start  = tx_start;
        acc      = req_valid & req_ready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_cmd;
        uart_update();
        drive_reqs();
        @(negedge clk);
        model_check();
    endtask

    // Output monitor: pops predicted transactions when the DUT presents them.
    always @(negedge clk) begin
        start_t e;
        if (tx_done) begin
            n_done++;
            if (contend) last_done = cyc;
        end
        if (tx_start || (sq.size() > 0 && sq[0].cyc <= cyc)) begin
            if (sq.size() == 0) begin
                check("unexpected_start", 32'(tx_start), 32'd0);
            end else begin
                e = sq.pop_front();
                check("start_cycle", 32'(cyc), 32'(e.cyc));
                check("start_pulse", 32'(tx_start), 32'd1);
                check("start_grant_id", 32'(grant_id), 32'(e.id));
                check("start_tx_data", 32'(tx_data), 32'(e.data));
            end
            if (tx_start) begin
                n_start++;
                if (contend) begin
                    check("contend_order", 32'(grant_id), 32'(contend_next));
                    contend_next = (contend_next + 1) % N;
                    if (last_done >= 0) check("done_to_start_gap", 32'(cyc - last_done), 32'd2);
                    last_done = -1;
                end
                if (arm) begin
                    first_id = int'(grant_id);
                    arm = 1'b0;
                end
            end
        end
        if (err_timeout || (eq.size() > 0 && eq[0] <= cyc)) begin
            if (err_timeout) n_err++;
            if (eq.size() == 0) begin
                check("unexpected_timeout", 32'(err_timeout), 32'd0);
            end else begin
                check("timeout_cycle", 32'(cyc), 32'(eq.pop_front()));
                check("timeout_pulse", 32'(err_timeout), 32'd1);
            end
        end
    end

    initial begin
        int base, base_d, base_e;
        bit ok;
        rst = 1'b1; rst_cmd = 1'b1; rand_rst = 1'b1; set_pend = 1'b0;
        req_valid = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
        pmode = P_NONE; u_mode = U_NORMAL; u_active = 1'b0; u_k = 0; u_d = D_NORMAL;
        m_active = 1'b0; m_last = N - 1; m_launch = 0; m_gid = 0; m_data = 0;
        rst_prev = 1'b0; s_start = 1'b0; acc = '0;
        contend = 1'b0; arm = 1'b0; contend_next = 0; last_done = -1; first_id = -1;

        // Reset with random requester activity
        repeat (3) step();
        rand_rst = 1'b0; rst_cmd = 1'b0; load('0, '0);
        step();

        // Single requester 2 with byte 0xA5
        pmode = P_SINGLE; base = n_start;
        load(4'b0100, 32'h00A5_0000);
        repeat (30) step();
        check("single_frames", 32'(n_start - base), 32'd1);
        check("single_idle_after", 32'(ctrl_busy), 32'd0);

        // All four contending from fresh priority
        rst_cmd = 1'b1; step(); step(); rst_cmd = 1'b0;
        pmode = P_CONTEND; contend = 1'b1; contend_next = 0; last_done = -1;
        base = n_start; base_d = n_done;
        load(4'hF, 32'h1312_1110);
        repeat (90) step();
        contend = 1'b0; pmode = P_NONE;
        repeat (70) step();
        check("contend_min_frames", 32'(n_start - base >= 6), 32'd1);
        check("contend_start_per_done", 32'(n_start - base), 32'(n_done - base_d));

        // Random traffic with a well-behaved transmitter
        pmode = P_RANDOM;
        repeat (1500) step();
        pmode = P_NONE;
        repeat (100) step();

        // Stub transmitter that never completes
        u_mode = U_STUB; pmode = P_RANDOM; base_e = n_err;
        repeat (300) step();
        check("timeouts_seen", 32'(n_err - base_e >= 3), 32'd1);
        pmode = P_NONE; u_mode = U_NORMAL;
        repeat (150) step();

        // tx_done coincident with the watchdog limit
        u_mode = U_COINC; pmode = P_SINGLE; base = n_start; base_e = n_err;
        load(4'b0001, 32'h0000_005A);
        repeat (60) step();
        check("coinc_no_error", 32'(n_err - base_e), 32'd0);
        check("coinc_frames", 32'(n_start - base), 32'd1);
        u_mode = U_NORMAL;

        // Reset while the serializer is busy
        load(4'b0010, 32'h0000_3C00);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (tx_busy) ok = 1'b1;
        end
        check("busy_before_reset", 32'(ok), 32'd1);
        repeat (3) step();
        rst_cmd = 1'b1; arm = 1'b1;
        load(4'hF, 32'h4433_2211);
        step(); step();
        rst_cmd = 1'b0;
        repeat (40) step();
        check("first_grant_after_reset", 32'(first_id), 32'd0);
        pmode = P_NONE;
        repeat (80) step();

        check("start_queue_drained", 32'(sq.size()), 32'd0);
        check("timeout_queue_drained", 32'(eq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
